ep_arb: RTL and testbench
=========================

// Module: ep_arb
// PURPOSE
//  Round-robin arbiter and TX mux sharing the single PCIe endpoint TRN tx interface between
//  NREQ transmit engines (tlp2ibuf mem_rd, mac2tlp write engine, irq_gen, ...).
//  Implements the req_ep / my_trn / drv_ep handshake those engines already speak.
//  Forwards the granted engine's TRN tx beats to the core.
//  Sits between the engines and the endpoint core.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  IDXW      2    clog2(NREQ), index width
//  GNT_TO    15   cycles a grant may wait for drv_ep before revocation (1..255)
// PORTS
//  clk             in   1        core clock; sole clock domain
//  rst_n           in   1        asynchronous, active-low reset
//  req_ep          in   NREQ     per-requester endpoint request (level)
//  drv_ep          in   NREQ     per-requester "driving endpoint" (level)
//  my_trn          out  NREQ     per-requester grant, one-hot or zero
//  req_td          in   NREQ*64  requester i data at [64i+63:64i]
//  req_trem_n      in   NREQ*8   requester i rem at [8i+7:8i]
//  req_tsof_n      in   NREQ     per-requester sof
//  req_teof_n      in   NREQ     per-requester eof
//  req_tsrc_rdy_n  in   NREQ     per-requester src_rdy
//  trn_td          out  64       to core
//  trn_trem_n      out  8        to core
//  trn_tsof_n      out  1        to core
//  trn_teof_n      out  1        to core
//  trn_tsrc_rdy_n  out  1        to core; trn_tdst_rdy_n/trn_tbuf_av go to engines directly
//  arb_err         out  1        sticky: drv_ep seen from a non-granted requester
// BEHAVIOUR
//  Reset: my_trn=0, arb_err=0, state IDLE, rr pointer=0, timeout cnt=0.
//  Reset: TRN outputs at idle values td=0, trem_n=8'hFF, tsof_n=teof_n=tsrc_rdy_n=1.
//  States:
//   IDLE  - any req_ep -> winner = first set bit at/after rr pointer (wrap NREQ-1->0)
//         - my_trn[w]<=1 next edge; ptr<=(w+1)%NREQ; cnt<=0; -> GRANT
//   GRANT - drv_ep[w]=1 -> BUSY
//         - else if req_ep[w]=0 or cnt==GNT_TO -> my_trn<=0, -> IDLE
//         - else cnt++
//   BUSY  - drv_ep[w]=0 sampled -> my_trn<=0, -> IDLE (req_ep ignored while drv_ep high)
//  Latency:
//   req_ep rising in IDLE at edge N -> my_trn high after edge N+1.
//   Release at edge N -> my_trn low after N+1; next grant no earlier than after N+2.
//   This gives one dead cycle with no grant between owners.
//  Grant is always held for >=1 cycle; never two bits of my_trn high.
//  Mux: combinational from registered grant index.
//   Outputs carry requester w's signals only while my_trn[w] & drv_ep[w].
//   Otherwise outputs hold idle values; never forward a non-granted requester.
//  Engines must drop drv_ep only after their final beat (teof_n=0 accepted); arbiter does not
//  inspect sof/eof framing.
//  drv_ep[j]=1 with my_trn[j]=0 (j != w, or in IDLE) -> arb_err<=1 (sticky until reset);
//  its beats are dropped.
//  Simultaneous requests: only rr order decides, so each requester is served within
//  NREQ grants.
//  Reset asserted mid-packet: outputs go idle immediately (async); the core sees a truncated TLP.
//  This is acceptable only under a global reset.
// STRUCTURE
//  ep_arb_pkg: state enum {IDLE,GRANT,BUSY}; TRN idle constants (TD_IDLE, TREM_IDLE=8'hFF).
//  Sub-module rr_pick: combinational rotate-priority encoder.
//   Inputs: req[NREQ], ptr[IDXW]. Outputs: vld, idx[IDXW].
//  Remainder: FSM, timeout counter, grant register, output mux in ep_arb.
// TESTING
//  1 Reset, req_ep=4'b0001, drv_ep[0] after 1 cycle, 3 beats, release.
//    -> my_trn=0001 one cycle after req; 3 beats reach core unchanged; my_trn=0 after release.
//  2 req_ep=4'b1111 held, each owner drives 1 beat then releases.
//    -> grant order 0,1,2,3,0; one idle cycle between grants.
//  3 req_ep[2]=1, drv_ep never asserted.
//    -> my_trn[2] drops after GNT_TO+1 = 16 cycles in GRANT; ptr=3; arb_err stays 0.
//  4 Owner 1 in BUSY, drv_ep[3] asserted with req_td[3]=64'hDEAD.
//    -> arb_err=1 next cycle; trn_td never 64'hDEAD; owner 1 traffic intact.
//  5 rst_n low mid-packet while owner 0 has tsrc_rdy_n=0.
//    -> same cycle my_trn=0, trn_tsrc_rdy_n=1, trn_trem_n=8'hFF.
//    -> After release, req_ep=1001 grants 0 first.
//  6 req_ep[0] falls in GRANT with drv_ep[0]=0.
//    -> grant revoked next cycle; the pending req_ep[1] is granted one cycle later.

Source files
------------

// File: rtl/ep_arb_pkg.sv
// ep_arb_pkg: shared constants for the endpoint TX arbiter.
//   - FSM state encodings for ep_arb (IDLE / GRANT / BUSY)
//   - TRN tx idle values driven to the core when no owner is forwarding
//   - width of the grant-timeout counter
package ep_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam logic [63:0] TD_IDLE   = 64'h0;
    localparam logic [7:0]  TREM_IDLE = 8'hFF;

    // Wide enough for the largest supported grant timeout (255).
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/ep_arb_rr_pick.sv
// ep_arb_rr_pick: combinational rotate-priority encoder.
// Returns the first set request bit at or after the pointer, wrapping NREQ-1 -> 0.
// Ports:
//   i_req  in  NREQ  request vector
//   i_ptr  in  IDXW  round-robin pointer (always < NREQ)
//   o_vld  out 1     at least one request set
//   o_idx  out IDXW  index of the winner (0 when o_vld is low)
module ep_arb_rr_pick
    import ep_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_vld,
    output logic [IDXW-1:0] o_idx
);

    logic [NREQ-1:0] w_rot;
    logic [IDXW:0]   w_sum;

    always_comb begin
        // Rotate so that bit 0 of w_rot corresponds to requester i_ptr.
        w_rot = NREQ'({i_req, i_req} >> i_ptr);
        o_vld = |w_rot;
        o_idx = '0;
        w_sum = '0;
        // Scan downward so the set bit closest to the pointer is assigned last and wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (IDXW + 1)'(k);
                if (w_sum >= (IDXW + 1)'(NREQ)) begin
                    w_sum = w_sum - (IDXW + 1)'(NREQ);
                end
                o_idx = w_sum[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/ep_arb.sv
// ep_arb: round-robin arbiter and TX mux sharing the PCIe endpoint TRN tx interface
// between NREQ transmit engines using the req_ep / my_trn / drv_ep handshake.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_ep[NREQ]        per-engine request (level)
//   i_drv_ep[NREQ]        per-engine "driving endpoint" (level)
//   o_my_trn[NREQ]        per-engine grant, one-hot or zero
//   i_req_td/trem_n/tsof_n/teof_n/tsrc_rdy_n   per-engine TRN tx beats
//   o_trn_td/trem_n/tsof_n/teof_n/tsrc_rdy_n   TRN tx beats to the core
//   o_arb_err             sticky: drv_ep seen from a non-granted engine
module ep_arb
    import ep_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IDXW   = 2,
    parameter int GNT_TO = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req_ep,
    input  logic [NREQ-1:0]    i_drv_ep,
    output logic [NREQ-1:0]    o_my_trn,
    input  logic [NREQ*64-1:0] i_req_td,
    input  logic [NREQ*8-1:0]  i_req_trem_n,
    input  logic [NREQ-1:0]    i_req_tsof_n,
    input  logic [NREQ-1:0]    i_req_teof_n,
    input  logic [NREQ-1:0]    i_req_tsrc_rdy_n,
    output logic [63:0]        o_trn_td,
    output logic [7:0]         o_trn_trem_n,
    output logic               o_trn_tsof_n,
    output logic               o_trn_teof_n,
    output logic               o_trn_tsrc_rdy_n,
    output logic               o_arb_err
);

    logic [1:0]       r_state, w_state_nxt;
    logic [IDXW-1:0]  r_gnt_idx, w_gnt_idx_nxt;
    logic [IDXW-1:0]  r_ptr, w_ptr_nxt;
    logic [NREQ-1:0]  r_my_trn, w_my_trn_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_arb_err;

    logic             w_pick_vld;
    logic [IDXW-1:0]  w_pick_idx;
    logic             w_own_req;
    logic             w_own_drv;
    logic             w_fwd;
    logic             w_intrude;

    ep_arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req (i_req_ep),
        .i_ptr (r_ptr),
        .o_vld (w_pick_vld),
        .o_idx (w_pick_idx)
    );

    assign w_own_req = i_req_ep[r_gnt_idx];
    assign w_own_drv = i_drv_ep[r_gnt_idx];
    // Any engine driving without holding the grant is a protocol violation.
    assign w_intrude = |(i_drv_ep & ~r_my_trn);

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_idx_nxt = r_gnt_idx;
        w_ptr_nxt     = r_ptr;
        w_my_trn_nxt  = r_my_trn;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_my_trn_nxt             = '0;
                    w_my_trn_nxt[w_pick_idx] = 1'b1;
                    w_gnt_idx_nxt            = w_pick_idx;
                    w_ptr_nxt = (w_pick_idx == IDXW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
                    w_cnt_nxt                = '0;
                    w_state_nxt              = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_own_drv) begin
                    w_state_nxt = ST_BUSY;
                end else if (!w_own_req || (r_cnt == CNT_W'(GNT_TO))) begin
                    w_my_trn_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_BUSY: begin
                // req_ep is irrelevant here; only the owner dropping drv_ep ends the tenure.
                if (!w_own_drv) begin
                    w_my_trn_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_my_trn_nxt = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_ptr     <= '0;
            r_my_trn  <= '0;
            r_cnt     <= '0;
            r_arb_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_my_trn  <= w_my_trn_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_intrude) begin
                r_arb_err <= 1'b1;
            end
        end
    end

    // Forward only while the registered owner is actually driving; a cleared grant
    // (including during reset) forces idle values regardless of the engines' inputs.
    assign w_fwd = r_my_trn[r_gnt_idx] & w_own_drv;

    always_comb begin
        o_trn_td         = TD_IDLE;
        o_trn_trem_n     = TREM_IDLE;
        o_trn_tsof_n     = 1'b1;
        o_trn_teof_n     = 1'b1;
        o_trn_tsrc_rdy_n = 1'b1;
        if (w_fwd) begin
            o_trn_td         = i_req_td[{r_gnt_idx, 6'd0} +: 64];
            o_trn_trem_n     = i_req_trem_n[{r_gnt_idx, 3'd0} +: 8];
            o_trn_tsof_n     = i_req_tsof_n[r_gnt_idx];
            o_trn_teof_n     = i_req_teof_n[r_gnt_idx];
            o_trn_tsrc_rdy_n = i_req_tsrc_rdy_n[r_gnt_idx];
        end
    end

    assign o_my_trn  = r_my_trn;
    assign o_arb_err = r_arb_err;

endmodule

// File: tb/tb_ep_arb.sv
// tb_ep_arb: self-checking bench for ep_arb. Engines are played by the bench; grant
// order is predicted by a reference model (rr pointer + "first requester at/after
// pointer" search) and beats are random data checked at the core side.
module tb_ep_arb;

    localparam int NREQ   = 4;
    localparam int IDXW   = 2;
    localparam int GNT_TO = 15;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req_ep = '0;
    logic [NREQ-1:0]    drv_ep = '0;
    logic [NREQ-1:0]    my_trn;
    logic [NREQ*64-1:0] req_td = '0;
    logic [NREQ*8-1:0]  req_trem_n = '1;
    logic [NREQ-1:0]    req_tsof_n = '1;
    logic [NREQ-1:0]    req_teof_n = '1;
    logic [NREQ-1:0]    req_tsrc_rdy_n = '1;
    logic [63:0]        trn_td;
    logic [7:0]         trn_trem_n;
    logic               trn_tsof_n;
    logic               trn_teof_n;
    logic               trn_tsrc_rdy_n;
    logic               arb_err;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;   // model round-robin pointer

    always #5 clk = ~clk;

    ep_arb #(
        .NREQ   (NREQ),
        .IDXW   (IDXW),
        .GNT_TO (GNT_TO)
    ) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_ep         (req_ep),
        .i_drv_ep         (drv_ep),
        .o_my_trn         (my_trn),
        .i_req_td         (req_td),
        .i_req_trem_n     (req_trem_n),
        .i_req_tsof_n     (req_tsof_n),
        .i_req_teof_n     (req_teof_n),
        .i_req_tsrc_rdy_n (req_tsrc_rdy_n),
        .o_trn_td         (trn_td),
        .o_trn_trem_n     (trn_trem_n),
        .o_trn_tsof_n     (trn_tsof_n),
        .o_trn_teof_n     (trn_teof_n),
        .o_trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .o_arb_err        (arb_err)
    );

    // Reference: first requester at or after ptr, wrapping; -1 if none.
    function automatic int f_pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] f_onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [63:0] td, input logic [7:0] rem,
                            input logic sof_n, input logic eof_n, input logic rdy_n);
        req_td[64*i +: 64]  = td;
        req_trem_n[8*i +: 8] = rem;
        req_tsof_n[i]       = sof_n;
        req_teof_n[i]       = eof_n;
        req_tsrc_rdy_n[i]   = rdy_n;
    endtask

    // Random garbage on every engine's beat lanes except 'keep'.
    task automatic noise(input int keep);
        for (int i = 0; i < NREQ; i++) begin
            if (i != keep) begin
                set_beat(i, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom));
            end
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_ptr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        noise(-1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (my_trn !== 4'b0000) begin
            n_fail++; $display("FAIL reset_my_trn: got %b want 0000", my_trn);
        end
        n_checks++;
        if (arb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_arb_err: got %b want 0", arb_err);
        end
        n_checks++;
        if (trn_td !== 64'h0) begin
            n_fail++; $display("FAIL reset_td: got %h want 0", trn_td);
        end
        n_checks++;
        if (trn_trem_n !== 8'hFF) begin
            n_fail++; $display("FAIL reset_trem: got %h want ff", trn_trem_n);
        end
        n_checks++;
        if ({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 111", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n});
        end
        rst_n = 1'b1;
        m_ptr = 0;
        @(posedge clk);
        #1;
    endtask

    // Single requester, three-beat packet.
    task automatic test_single;
        logic [63:0] td;
        logic [7:0]  rem;
        req_ep = 4'b0001;
        #1;
        n_checks++;
        if (my_trn !== 4'b0000) begin
            n_fail++; $display("FAIL single_pre: got %b want 0000", my_trn);
        end
        tick;
        n_checks++;
        if (my_trn !== 4'b0001) begin
            n_fail++; $display("FAIL single_grant: got %b want 0001", my_trn);
        end
        m_ptr = 1;
        tick;   // engine waits one cycle before driving
        for (int b = 0; b < 3; b++) begin
            td  = {$urandom, $urandom};
            rem = 8'($urandom);
            noise(0);
            set_beat(0, td, rem, (b != 0), (b != 2), 1'b0);
            drv_ep[0] = 1'b1;
            #1;
            n_checks++;
            if (trn_td !== td || trn_trem_n !== rem) begin
                n_fail++;
                $display("FAIL single_beat%0d: got td=%h rem=%h want td=%h rem=%h", b, trn_td,
                         trn_trem_n, td, rem);
            end
            n_checks++;
            if ({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n} !== {(b != 0), (b != 2), 1'b0}) begin
                n_fail++;
                $display("FAIL single_ctl%0d: got %b want %b", b,
                         {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}, {(b != 0), (b != 2), 1'b0});
            end
            tick;
        end
        drv_ep = '0;
        req_ep = '0;
        noise(-1);
        #1;
        n_checks++;
        if (trn_tsrc_rdy_n !== 1'b1 || trn_td !== 64'h0 || my_trn !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_release: got rdy=%b td=%h my_trn=%b want 1/0/0001",
                     trn_tsrc_rdy_n, trn_td, my_trn);
        end
        tick;
        n_checks++;
        if (my_trn !== 4'b0000) begin
            n_fail++; $display("FAIL single_revoke: got %b want 0000", my_trn);
        end
    endtask

    // All requesting first (fixed 0,1,2,3,0 order from reset), then random masks.
    task automatic test_round_robin;
        logic [NREQ-1:0] mask;
        logic [63:0]     td;
        int              w;
        do_reset;
        mask   = 4'b1111;
        req_ep = mask;
        for (int g = 0; g < 24; g++) begin
            tick;
            w = f_pick(mask, m_ptr);
            n_checks++;
            if (my_trn !== f_onehot(w)) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, my_trn, f_onehot(w));
            end
            m_ptr = (w + 1) % NREQ;
            td = {$urandom, $urandom};
            noise(w);
            set_beat(w, td, 8'h00, 1'b0, 1'b0, 1'b0);
            drv_ep[w] = 1'b1;
            #1;
            n_checks++;
            if (trn_td !== td || trn_tsrc_rdy_n !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got td=%h rdy=%b want td=%h rdy=0", g, trn_td,
                         trn_tsrc_rdy_n, td);
            end
            tick;
            drv_ep = '0;
            mask   = (g < 4) ? 4'b1111 : (g == 23) ? 4'b0000 : 4'($urandom_range(1, 15));
            req_ep = mask;
            tick;
            n_checks++;
            if (my_trn !== 4'b0000) begin
                n_fail++; $display("FAIL rr_dead%0d: got %b want 0000", g, my_trn);
            end
        end
    endtask

    // Grant without drv_ep is revoked after GNT_TO+1 cycles in GRANT.
    task automatic test_timeout;
        int w;
        req_ep = 4'b0100;
        tick;
        w = f_pick(4'b0100, m_ptr);
        n_checks++;
        if (my_trn !== f_onehot(w)) begin
            n_fail++; $display("FAIL to_grant: got %b want %b", my_trn, f_onehot(w));
        end
        m_ptr = (w + 1) % NREQ;
        for (int k = 1; k <= GNT_TO; k++) begin
            tick;
            n_checks++;
            if (my_trn !== 4'b0100) begin
                n_fail++; $display("FAIL to_hold%0d: got %b want 0100", k, my_trn);
            end
        end
        tick;
        n_checks++;
        if (my_trn !== 4'b0000) begin
            n_fail++; $display("FAIL to_revoke: got %b want 0000", my_trn);
        end
        n_checks++;
        if (arb_err !== 1'b0) begin
            n_fail++; $display("FAIL to_err: got %b want 0", arb_err);
        end
        req_ep = 4'b1111;
        tick;
        w = f_pick(4'b1111, m_ptr);
        n_checks++;
        if (my_trn !== f_onehot(w)) begin
            n_fail++; $display("FAIL to_next_ptr: got %b want %b", my_trn, f_onehot(w));
        end
        m_ptr = (w + 1) % NREQ;
        req_ep = '0;
        tick;
        n_checks++;
        if (my_trn !== 4'b0000) begin
            n_fail++; $display("FAIL to_cleanup: got %b want 0000", my_trn);
        end
    endtask

    // Non-granted engine drives while engine 1 owns the interface.
    task automatic test_intruder;
        logic [63:0] td;
        int          w;
        req_ep = 4'b0010;
        tick;
        w = f_pick(4'b0010, m_ptr);
        n_checks++;
        if (my_trn !== f_onehot(w)) begin
            n_fail++; $display("FAIL intr_grant: got %b want %b", my_trn, f_onehot(w));
        end
        m_ptr = (w + 1) % NREQ;
        td = {$urandom, $urandom};
        set_beat(1, td, 8'h00, 1'b0, 1'b1, 1'b0);
        drv_ep[1] = 1'b1;
        tick;
        td = {$urandom, $urandom};
        set_beat(1, td, 8'h00, 1'b1, 1'b1, 1'b0);
        set_beat(3, 64'hDEAD, 8'h00, 1'b0, 1'b0, 1'b0);
        drv_ep[3] = 1'b1;
        #1;
        n_checks++;
        if (trn_td !== td || arb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL intr_first: got td=%h err=%b want td=%h err=0", trn_td, arb_err, td);
        end
        tick;
        td = {$urandom, $urandom};
        set_beat(1, td, 8'h0F, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (arb_err !== 1'b1) begin
            n_fail++; $display("FAIL intr_err: got %b want 1", arb_err);
        end
        n_checks++;
        if (trn_td !== td || my_trn !== 4'b0010) begin
            n_fail++;
            $display("FAIL intr_owner: got td=%h my_trn=%b want td=%h my_trn=0010", trn_td,
                     my_trn, td);
        end
        drv_ep[3] = 1'b0;
        tick;
        drv_ep = '0;
        req_ep = '0;
        #1;
        n_checks++;
        if (trn_td !== 64'h0) begin
            n_fail++; $display("FAIL intr_idle: got %h want 0", trn_td);
        end
        tick;
        n_checks++;
        if (my_trn !== 4'b0000 || arb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL intr_sticky: got my_trn=%b err=%b want 0000/1", my_trn, arb_err);
        end
    endtask

    // Asynchronous reset while engine 0 is mid-packet.
    task automatic test_async_reset;
        int w;
        req_ep = 4'b0001;
        tick;
        w = f_pick(4'b0001, m_ptr);
        n_checks++;
        if (my_trn !== f_onehot(w)) begin
            n_fail++; $display("FAIL ar_grant: got %b want %b", my_trn, f_onehot(w));
        end
        set_beat(0, {$urandom, $urandom}, 8'h00, 1'b0, 1'b1, 1'b0);
        drv_ep[0] = 1'b1;
        #1;
        n_checks++;
        if (trn_tsrc_rdy_n !== 1'b0) begin
            n_fail++; $display("FAIL ar_busy: got rdy=%b want 0", trn_tsrc_rdy_n);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (my_trn !== 4'b0000 || trn_tsrc_rdy_n !== 1'b1 || trn_trem_n !== 8'hFF) begin
            n_fail++;
            $display("FAIL ar_idle: got my_trn=%b rdy=%b rem=%h want 0000/1/ff", my_trn,
                     trn_tsrc_rdy_n, trn_trem_n);
        end
        n_checks++;
        if (arb_err !== 1'b0) begin
            n_fail++; $display("FAIL ar_err_clr: got %b want 0", arb_err);
        end
        drv_ep = '0;
        req_ep = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_ptr  = 0;
        req_ep = 4'b1001;
        tick;
        w = f_pick(4'b1001, m_ptr);
        n_checks++;
        if (my_trn !== f_onehot(w)) begin
            n_fail++; $display("FAIL ar_regrant: got %b want %b", my_trn, f_onehot(w));
        end
        m_ptr = (w + 1) % NREQ;
        req_ep = '0;
        tick;
        n_checks++;
        if (my_trn !== 4'b0000) begin
            n_fail++; $display("FAIL ar_cleanup: got %b want 0000", my_trn);
        end
    endtask

    // Granted engine withdraws its request before driving; pending one follows.
    task automatic test_req_drop;
        int a, b, w, p;
        logic [NREQ-1:0] mask;
        for (int it = 0; it < 6; it++) begin
            a    = $urandom_range(0, NREQ - 1);
            b    = (a + 1 + $urandom_range(0, NREQ - 2)) % NREQ;
            mask = f_onehot(a) | f_onehot(b);
            req_ep = mask;
            tick;
            w = f_pick(mask, m_ptr);
            p = (w == a) ? b : a;
            n_checks++;
            if (my_trn !== f_onehot(w)) begin
                n_fail++; $display("FAIL drop_grant%0d: got %b want %b", it, my_trn, f_onehot(w));
            end
            m_ptr  = (w + 1) % NREQ;
            req_ep = f_onehot(p);
            tick;
            n_checks++;
            if (my_trn !== 4'b0000) begin
                n_fail++; $display("FAIL drop_revoke%0d: got %b want 0000", it, my_trn);
            end
            tick;
            n_checks++;
            if (my_trn !== f_onehot(p)) begin
                n_fail++;
                $display("FAIL drop_pending%0d: got %b want %b", it, my_trn, f_onehot(p));
            end
            m_ptr  = (p + 1) % NREQ;
            req_ep = '0;
            tick;
            n_checks++;
            if (my_trn !== 4'b0000) begin
                n_fail++; $display("FAIL drop_cleanup%0d: got %b want 0000", it, my_trn);
            end
        end
        n_checks++;
        if (arb_err !== 1'b0) begin
            n_fail++; $display("FAIL drop_err: got %b want 0", arb_err);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_intruder;
        test_async_reset;
        test_req_drop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
